// File: rtl/ov7670_frame_capture.sv
// OV7670 capture engine: oversamples the camera bus, pairs bytes into pixels,
// converts them to an 8-bit format and writes a clipped frame into RAM.
module ov7670_frame_capture #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 120,
  parameter int ADDR_WIDTH    = 15
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  PCLK,
  input  logic                  HREF,
  input  logic                  VSYNC,
  input  logic [7:0]            CAM_DATA,
  input  logic                  CAPTURE_EN,
  input  logic [1:0]            MODE,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [7:0]            W_DATA,
  output logic                  W_EN,
  output logic                  FRAME_DONE,
  output logic [7:0]            FRAME_COUNT,
  output logic                  SYNC_ERR,
  output logic                  BUSY
);
  localparam int COL_W = $clog2(SCREEN_WIDTH + 1);
  localparam int ROW_W = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [COL_W-1:0]      COL_MAX   = COL_W'(SCREEN_WIDTH);
  localparam logic [ROW_W-1:0]      ROW_MAX   = ROW_W'(SCREEN_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(SCREEN_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} state_t;

  // Bit 0/1 are the synchronizer, bit 2 is the edge-detect history.
  logic [2:0] pclk_q, pclk_d, href_q, href_d, vs_q, vs_d;
  logic [7:0] dat1_q, dat1_d, dat2_q, dat2_d;
  logic       pix_q, pix_d, le_q, le_d, vr_q, vr_d, vf_q, vf_d;
  logic [7:0] evdat_q, evdat_d;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic                  phase_q, phase_d;
  logic [7:0]            b1_q, b1_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_data_q, w_data_d;
  logic                  w_en_q, w_en_d, frame_done_q, frame_done_d;
  logic [7:0]            frame_count_q, frame_count_d;
  logic                  sync_err_q, sync_err_d, busy_q, busy_d;
  logic [7:0]            pix_byte;

  always_comb begin
    pclk_d  = {pclk_q[1:0], PCLK};
    href_d  = {href_q[1:0], HREF};
    vs_d    = {vs_q[1:0], VSYNC};
    dat1_d  = CAM_DATA;
    dat2_d  = dat1_q;
    // Events are registered once so the datapath sees a clean single-cycle strobe.
    pix_d   = pclk_q[1] & ~pclk_q[2] & href_q[1];
    le_d    = ~href_q[1] & href_q[2];
    vr_d    = vs_q[1] & ~vs_q[2];
    vf_d    = ~vs_q[1] & vs_q[2];
    evdat_d = dat2_q;
  end

  always_comb begin
    case (mode_q)
      2'd1:    pix_byte = b1_q;
      2'd2:    pix_byte = 8'(col_q) ^ 8'(row_q);
      default: pix_byte = {b1_q[7:5], b1_q[2:0], evdat_q[4:3]};
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    phase_d       = phase_q;
    b1_d          = b1_q;
    col_d         = col_q;
    row_d         = row_q;
    line_base_d   = line_base_q;
    w_addr_d      = w_addr_q;
    w_data_d      = w_data_q;
    w_en_d        = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    sync_err_d    = sync_err_q;
    case (state_q)
      S_IDLE: if (vr_q && CAPTURE_EN) state_d = S_WAIT;
      S_WAIT: if (vf_q) begin
        state_d     = S_ACTIVE;
        mode_d      = (MODE == 2'd3) ? 2'd0 : MODE;
        row_d       = '0;
        col_d       = '0;
        phase_d     = 1'b0;
        line_base_d = '0;
      end
      S_ACTIVE: begin
        if (le_q) begin
          col_d = '0;
          if (row_q < ROW_MAX) begin
            row_d       = row_q + 1'b1;
            line_base_d = line_base_q + LINE_STEP;
          end
          if (phase_q) begin
            phase_d    = 1'b0;
            sync_err_d = 1'b1;
          end
        end else if (pix_q) begin
          if (!phase_q) begin
            b1_d    = evdat_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (col_q < COL_MAX) col_d = col_q + 1'b1;
            if (col_q < COL_MAX && row_q < ROW_MAX) begin
              w_en_d   = 1'b1;
              w_addr_d = line_base_q + ADDR_WIDTH'(col_q);
              w_data_d = pix_byte;
            end
          end
        end
        if (vr_q) begin
          if (phase_q && !le_q) sync_err_d = 1'b1;
          phase_d       = 1'b0;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          state_d       = CAPTURE_EN ? S_WAIT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ACTIVE);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pclk_q <= '0; href_q <= '0; vs_q <= '0; dat1_q <= '0; dat2_q <= '0;
      pix_q <= 1'b0; le_q <= 1'b0; vr_q <= 1'b0; vf_q <= 1'b0; evdat_q <= '0;
      state_q <= S_IDLE; mode_q <= '0; phase_q <= 1'b0; b1_q <= '0;
      col_q <= '0; row_q <= '0; line_base_q <= '0;
      w_addr_q <= '0; w_data_q <= '0; w_en_q <= 1'b0; frame_done_q <= 1'b0;
      frame_count_q <= '0; sync_err_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      pclk_q <= pclk_d; href_q <= href_d; vs_q <= vs_d; dat1_q <= dat1_d; dat2_q <= dat2_d;
      pix_q <= pix_d; le_q <= le_d; vr_q <= vr_d; vf_q <= vf_d; evdat_q <= evdat_d;
      state_q <= state_d; mode_q <= mode_d; phase_q <= phase_d; b1_q <= b1_d;
      col_q <= col_d; row_q <= row_d; line_base_q <= line_base_d;
      w_addr_q <= w_addr_d; w_data_q <= w_data_d; w_en_q <= w_en_d; frame_done_q <= frame_done_d;
      frame_count_q <= frame_count_d; sync_err_q <= sync_err_d; busy_q <= busy_d;
    end
  end

  assign W_ADDR      = w_addr_q;
  assign W_DATA      = w_data_q;
  assign W_EN        = w_en_q;
  assign FRAME_DONE  = frame_done_q;
  assign FRAME_COUNT = frame_count_q;
  assign SYNC_ERR    = sync_err_q;
  assign BUSY        = busy_q;
endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Bench for ov7670_frame_capture: drives camera frames and compares RAM writes
// against a pixel-list model built from line/byte counts and the format rules.
module tb_ov7670_frame_capture;
  localparam int SW = 4, SH = 2, AW = 15;

  logic          CLOCK = 0, RESET = 1, PCLK = 0, HREF = 0, VSYNC = 0, CAPTURE_EN = 0;
  logic [7:0]    CAM_DATA = 0;
  logic [1:0]    MODE = 0;
  logic [AW-1:0] W_ADDR;
  logic [7:0]    W_DATA, FRAME_COUNT;
  logic          W_EN, FRAME_DONE, SYNC_ERR, BUSY;

  ov7670_frame_capture #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .ADDR_WIDTH(AW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .PCLK(PCLK), .HREF(HREF), .VSYNC(VSYNC),
    .CAM_DATA(CAM_DATA), .CAPTURE_EN(CAPTURE_EN), .MODE(MODE),
    .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_EN(W_EN), .FRAME_DONE(FRAME_DONE),
    .FRAME_COUNT(FRAME_COUNT), .SYNC_ERR(SYNC_ERR), .BUSY(BUSY));

  always #5 CLOCK = ~CLOCK;

  int errors = 0, checks = 0, done_cnt = 0, exp_fc = 0, d0;
  logic [AW+7:0] got_q[$], exp_q[$];

  always @(negedge CLOCK) begin
    if (W_EN) got_q.push_back({W_ADDR, W_DATA});
    if (FRAME_DONE) done_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(int m, logic [7:0] b1, logic [7:0] b2, int p, int r);
    case (m)
      1:       return b1;
      2:       return 8'(p ^ r);
      default: return {b1[7:5], b1[2:0], b2[4:3]};
    endcase
  endfunction

  // One camera line; expected writes are pushed when the second byte of a pair goes out.
  task automatic drive_line(int r, int n, int m, logic fixed, logic [7:0] fb1, logic [7:0] fb2,
                            logic live);
    logic [7:0] b, prev;
    prev = 0;
    HREF = 1; #40;
    for (int j = 0; j < n; j++) begin
      b = fixed ? ((j % 2 == 0) ? fb1 : fb2) : 8'($urandom);
      PCLK = 0; CAM_DATA = b; #40;
      PCLK = 1; #40;
      if (live && (j % 2 == 1) && (j / 2) < SW && r < SH)
        exp_q.push_back({AW'(r * SW + j / 2), pix(m, prev, b, j / 2, r)});
      prev = b;
    end
    PCLK = 0; #40;
    HREF = 0; #80;
  endtask

  // Assumes VSYNC high on entry and the block waiting for the falling edge.
  task automatic run_frame(int fmode, int nlines, int n, int n_first, logic fixed,
                           logic [7:0] fb1, logic [7:0] fb2, int mode_mid, logic drop_en, logic live);
    int m;
    m = (fmode == 3) ? 0 : fmode;
    MODE = 2'(fmode); VSYNC = 0; #100;
    for (int r = 0; r < nlines; r++) begin
      if (r == 1 && mode_mid >= 0) MODE = 2'(mode_mid);
      if (r == 1 && drop_en) CAPTURE_EN = 0;
      drive_line(r, (r == 0) ? n_first : n, m, fixed, fb1, fb2, live);
      if (r == 0 && live) check("busy_mid", BUSY, 1);
    end
    VSYNC = 1; #100;
  endtask

  task automatic compare_frame(string tag);
    check({tag, "_cnt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_wr"}, got_q[i], exp_q[i]);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic frame_end_checks(string tag, int ndone, logic err);
    check({tag, "_done"}, done_cnt - d0, ndone);
    check({tag, "_fc"}, FRAME_COUNT, exp_fc);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_serr"}, SYNC_ERR, err);
  endtask

  initial begin
    int maxa, fm, nl, nb;
    // Reset with noise on the camera pins
    RESET = 1;
    for (int i = 0; i < 3; i++) begin
      PCLK = 1'($urandom); HREF = 1'($urandom); VSYNC = 1'($urandom); CAM_DATA = 8'($urandom);
      @(posedge CLOCK);
    end
    @(negedge CLOCK);
    check("rst_addr", W_ADDR, 0);
    check("rst_data", W_DATA, 0);
    check("rst_wen", W_EN, 0);
    check("rst_done", FRAME_DONE, 0);
    check("rst_fc", FRAME_COUNT, 0);
    check("rst_serr", SYNC_ERR, 0);
    check("rst_busy", BUSY, 0);
    PCLK = 0; HREF = 0; VSYNC = 0; CAM_DATA = 0;
    @(negedge CLOCK); RESET = 0;
    repeat (5) @(negedge CLOCK);
    check("rst_nowr", got_q.size(), 0);
    got_q.delete();

    CAPTURE_EN = 1; VSYNC = 1; #100;

    // Mode 0, fixed bytes
    d0 = done_cnt;
    run_frame(0, 2, 8, 8, 1, 8'hE7, 8'h18, -1, 0, 1);
    exp_fc++;
    compare_frame("m0");
    frame_end_checks("m0", 1, 0);

    // Clipping: 6 pixels x 3 lines into a 4x2 window
    d0 = done_cnt;
    run_frame(0, 3, 12, 12, 0, 0, 0, -1, 0, 1);
    exp_fc++;
    maxa = 0;
    foreach (got_q[i]) if (int'(got_q[i][AW+7:8]) > maxa) maxa = int'(got_q[i][AW+7:8]);
    check("clip_max", maxa, 7);
    compare_frame("clip");
    frame_end_checks("clip", 1, 0);

    // Mode 1 with MODE switched mid-frame
    d0 = done_cnt;
    run_frame(1, 2, 8, 8, 1, 8'h55, 8'h80, 2, 0, 1);
    exp_fc++;
    compare_frame("m1");
    frame_end_checks("m1", 1, 0);

    // Mode 2 test pattern, camera bytes only pace it
    d0 = done_cnt;
    run_frame(2, 2, 8, 8, 0, 0, 0, 1, 0, 1);
    exp_fc++;
    check("m2_px31", (got_q.size() > 7) ? got_q[7] : 23'h7fffff, {15'd7, 8'h02});
    compare_frame("m2");
    frame_end_checks("m2", 1, 0);

    // Random frames, including mode 3
    for (int f = 0; f < 4; f++) begin
      fm = (f == 0) ? 3 : int'($urandom_range(0, 3));
      nl = int'($urandom_range(1, 3));
      nb = 2 * int'($urandom_range(1, 6));
      d0 = done_cnt;
      run_frame(fm, nl, nb, nb, 0, 0, 0, -1, 0, 1);
      exp_fc++;
      compare_frame("rnd");
      frame_end_checks("rnd", 1, 0);
    end

    // Odd byte count on the first line
    d0 = done_cnt;
    run_frame(0, 2, 8, 7, 0, 0, 0, -1, 0, 1);
    exp_fc++;
    compare_frame("odd");
    frame_end_checks("odd", 1, 1);

    // CAPTURE_EN dropped mid-frame: this frame finishes, the next one is ignored
    d0 = done_cnt;
    run_frame(1, 2, 8, 8, 0, 0, 0, -1, 1, 1);
    exp_fc++;
    compare_frame("drop");
    frame_end_checks("drop", 1, 1);
    d0 = done_cnt;
    VSYNC = 0; #100; VSYNC = 1; #100;
    run_frame(0, 2, 8, 8, 0, 0, 0, -1, 0, 0);
    compare_frame("idle");
    frame_end_checks("idle", 0, 1);

    // Reset in the middle of a frame
    CAPTURE_EN = 1;
    VSYNC = 0; #100; VSYNC = 1; #100;
    MODE = 2; VSYNC = 0; #100;
    drive_line(0, 8, 2, 0, 0, 0, 1);
    @(negedge CLOCK); RESET = 1;
    repeat (2) @(negedge CLOCK);
    RESET = 0;
    @(negedge CLOCK);
    exp_fc = 0;
    d0 = done_cnt;
    check("mrst_busy", BUSY, 0);
    drive_line(1, 8, 2, 0, 0, 0, 0);
    VSYNC = 1; #100;
    compare_frame("mrst");
    frame_end_checks("mrst", 0, 0);

    // Capture resumes after a full VSYNC sequence
    d0 = done_cnt;
    run_frame(1, 2, 8, 8, 0, 0, 0, -1, 0, 1);
    exp_fc++;
    compare_frame("resume");
    frame_end_checks("resume", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
